// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline (between decode and memory access).
// Registers the decode bundle, selects ALU operands, runs the ALU, owns HI/LO,
// and drives the EX->MEM bundle, the data-SRAM request and the EX forwarding taps.
// Build option EX_DIV_EN: when defined, div/divu run on a 32-step restoring
// divider that stalls the pipeline; when undefined, div/divu are NOPs and
// stallreq_for_ex is tied low.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_STEPS    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_rf_we,
  output logic [4:0]              ex_rf_waddr,
  output logic [31:0]             ex_ex_result,
  output logic                    stallreq_for_ex
);

  // Decode -> execute bundle, most significant field first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;     // add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    logic [2:0]  src1_sel;   // rs_val, pc, shamt
    logic [3:0]  src2_sel;   // rt_val, sext imm, 8, zext imm
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } id_ex_t;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

  id_ex_t      ex_q, ex_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] src1, src2, imm_sext, imm_zext;
  logic [31:0] alu_sum, alu_res, slt_res, sltu_res, sra_res, ex_result;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic        is_special;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu;
  logic [63:0] prod_s, prod_u;
  logic        div_wr;
  logic [31:0] div_quot, div_rem;

  // Stall bits belonging to other stages are not used here.
  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // Load, bubble or hold the decode bundle according to the stall vector.
  always_comb begin
    // NOTE: ex_d gets a default first so every path assigns it and no latch is inferred.
    ex_d = ex_q;
    if (!stall[2])      ex_d = id_ex_t'(id_to_ex_bus);
    else if (!stall[3]) ex_d = '0;
  end

  // Decode bundle register; reset loads a bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // Operand selection (one-hot selects, unused select yields zero).
  assign imm_sext = {{16{ex_q.inst[15]}}, ex_q.inst[15:0]};
  assign imm_zext = {16'h0, ex_q.inst[15:0]};
  assign src1 = ({32{ex_q.src1_sel[0]}} & ex_q.rs_val)
              | ({32{ex_q.src1_sel[1]}} & ex_q.pc)
              | ({32{ex_q.src1_sel[2]}} & {27'b0, ex_q.inst[10:6]});
  assign src2 = ({32{ex_q.src2_sel[0]}} & ex_q.rt_val)
              | ({32{ex_q.src2_sel[1]}} & imm_sext)
              | ({32{ex_q.src2_sel[2]}} & 32'd8)
              | ({32{ex_q.src2_sel[3]}} & imm_zext);

  assign shamt    = src1[4:0];
  assign alu_sum  = src1 + src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  // Kept in its own signed assignment so the shift stays arithmetic.
  assign sra_res  = $signed(src2) >>> shamt;

  // One-hot ALU result mux; an all-zero alu_op yields zero.
  always_comb begin
    alu_res = '0;
    if (ex_q.alu_op[11]) alu_res = alu_res | alu_sum;
    if (ex_q.alu_op[10]) alu_res = alu_res | (src1 - src2);
    if (ex_q.alu_op[9])  alu_res = alu_res | slt_res;
    if (ex_q.alu_op[8])  alu_res = alu_res | sltu_res;
    if (ex_q.alu_op[7])  alu_res = alu_res | (src1 & src2);
    if (ex_q.alu_op[6])  alu_res = alu_res | ~(src1 | src2);
    if (ex_q.alu_op[5])  alu_res = alu_res | (src1 | src2);
    if (ex_q.alu_op[4])  alu_res = alu_res | (src1 ^ src2);
    if (ex_q.alu_op[3])  alu_res = alu_res | (src2 << shamt);
    if (ex_q.alu_op[2])  alu_res = alu_res | (src2 >> shamt);
    if (ex_q.alu_op[1])  alu_res = alu_res | sra_res;
    if (ex_q.alu_op[0])  alu_res = alu_res | {src2[15:0], 16'h0};
  end

  // HI/LO instruction decode; a bubble (inst == 0) never touches HI/LO.
  assign funct      = ex_q.inst[5:0];
  assign is_special = (ex_q.inst[31:26] == 6'b0) && (ex_q.inst != 32'b0);
  assign is_mfhi    = is_special && (funct == FN_MFHI);
  assign is_mflo    = is_special && (funct == FN_MFLO);
  assign is_mthi    = is_special && (funct == FN_MTHI);
  assign is_mtlo    = is_special && (funct == FN_MTLO);
  assign is_mult    = is_special && (funct == FN_MULT);
  assign is_multu   = is_special && (funct == FN_MULTU);

  assign prod_s = $signed({{32{ex_q.rs_val[31]}}, ex_q.rs_val})
                * $signed({{32{ex_q.rt_val[31]}}, ex_q.rt_val});
  assign prod_u = {32'b0, ex_q.rs_val} * {32'b0, ex_q.rt_val};

  // HI/LO next state: moves, single-cycle multiply and divider completion.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_mthi)  hi_d = ex_q.rs_val;
    if (is_mtlo)  lo_d = ex_q.rs_val;
    if (is_mult)  {hi_d, lo_d} = prod_s;
    if (is_multu) {hi_d, lo_d} = prod_u;
    if (div_wr) begin
      hi_d = div_rem;
      lo_d = div_quot;
    end
  end

  // HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef EX_DIV_EN
  localparam int CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  div_state_e state_q, state_d;
  logic [31:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, dvz_q, dvz_d;
  // Set once a div has finished; blocks a restart until a new bundle is latched.
  logic div_seen_q, div_seen_d;

  logic        is_div, div_signed, rs_neg, rt_neg, bus_load, step_ge;
  logic [31:0] rs_abs, rt_abs, rem_diff;
  logic [32:0] rem_sh;

  assign div_signed = (funct == 6'h1A);
  assign is_div     = is_special && (div_signed || (funct == 6'h1B));
  assign rs_neg     = div_signed && ex_q.rs_val[31];
  assign rt_neg     = div_signed && ex_q.rt_val[31];
  assign rs_abs     = rs_neg ? (~ex_q.rs_val + 32'd1) : ex_q.rs_val;
  assign rt_abs     = rt_neg ? (~ex_q.rt_val + 32'd1) : ex_q.rt_val;
  assign bus_load   = !stall[2] || !stall[3];

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh   = {rem_q, quot_q[31]};
  assign step_ge  = rem_sh >= {1'b0, dvs_q};
  assign rem_diff = rem_sh[31:0] - dvs_q;

  assign div_quot = dvz_q ? 32'hFFFF_FFFF : (qneg_q ? (~quot_q + 32'd1) : quot_q);
  assign div_rem  = rneg_q ? (~rem_q + 32'd1) : rem_q;

  // Divider FSM: next state, datapath updates and stall request.
  always_comb begin
    state_d         = state_q;
    quot_d          = quot_q;
    rem_d           = rem_q;
    dvs_d           = dvs_q;
    cnt_d           = cnt_q;
    qneg_d          = qneg_q;
    rneg_d          = rneg_q;
    dvz_d           = dvz_q;
    div_seen_d      = div_seen_q;
    stallreq_for_ex = 1'b0;
    div_wr          = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (is_div && !div_seen_q) begin
          stallreq_for_ex = 1'b1;
          quot_d  = rs_abs;
          dvs_d   = rt_abs;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = rs_neg ^ rt_neg;
          rneg_d  = rs_neg;
          dvz_d   = (ex_q.rt_val == 32'b0);
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        stallreq_for_ex = 1'b1;
        rem_d  = step_ge ? rem_diff : rem_sh[31:0];
        quot_d = {quot_q[30:0], step_ge};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        div_wr     = 1'b1;
        div_seen_d = 1'b1;
        state_d    = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (bus_load) div_seen_d = 1'b0;
  end

  // Divider registers; reset abandons any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      quot_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dvz_q      <= 1'b0;
      div_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dvz_q      <= dvz_d;
      div_seen_q <= div_seen_d;
    end
  end
`else
  // No divider: div/divu fall through as NOPs.
  localparam int unused_div_steps = DIV_STEPS;
  assign stallreq_for_ex = 1'b0;
  assign div_wr          = 1'b0;
  assign div_quot        = '0;
  assign div_rem         = '0;
`endif

  // Outputs are combinational from the bundle register.
  assign ex_result     = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
  assign ex_to_mem_bus = {ex_q.pc, ex_q.ram_en, ex_q.ram_wen, ex_q.sel_rf_res,
                          ex_q.rf_we, ex_q.rf_waddr, ex_result};

  assign data_sram_en    = ex_q.ram_en;
  assign data_sram_wen   = ex_q.ram_wen;
  assign data_sram_addr  = alu_sum;
  assign data_sram_wdata = ex_q.rt_val;

  assign ex_rf_we     = ex_q.rf_we && !stallreq_for_ex;
  assign ex_rf_waddr  = ex_q.rf_waddr;
  assign ex_ex_result = ex_result;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected EX->MEM bundles,
// ALU/HI-LO coverage, stall bubble/hold, and divider behaviour (EX_DIV_EN).
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1_sel;
    logic [3:0]  src2_sel;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } ins_t;

  localparam logic [11:0] OP_NONE = 12'h000;
  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_tb = '0;
  logic [5:0]  stall;
  ins_t        id_bus = '0;
  logic [75:0] ex_to_mem_bus;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_ex_result;
  logic        stallreq_for_ex;

  // Stall controller model: a divide stalls IF/ID/EX, MEM takes bubbles.
  assign stall = stall_tb | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_rf_we        (ex_rf_we),
    .ex_rf_waddr     (ex_rf_waddr),
    .ex_ex_result    (ex_ex_result),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: {expected stallreq, expected EX->MEM bundle} plus a tag.
  logic [76:0] sb[$];
  string       sb_tag[$];

  task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [11:0] op, input logic [2:0] s1,
                              input logic [3:0] s2, input logic we, input logic [4:0] wa,
                              input logic [31:0] rs, input logic [31:0] rt);
    ins_t i;
    i          = '0;
    i.pc       = pc;
    i.inst     = inst;
    i.alu_op   = op;
    i.src1_sel = s1;
    i.src2_sel = s2;
    i.rf_we    = we;
    i.rf_waddr = wa;
    i.rs_val   = rs;
    i.rt_val   = rt;
    return i;
  endfunction

  function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [75:0] exp_bus(input ins_t i, input logic [31:0] res);
    return {i.pc, i.ram_en, i.ram_wen, i.sel_rf_res, i.rf_we, i.rf_waddr, res};
  endfunction

  // Pop the oldest expectation and compare it against what EX presents now.
  task automatic collect();
    logic [76:0] e;
    string       t;
    e = sb.pop_front();
    t = sb_tag.pop_front();
    check({t, ".bus"}, ex_to_mem_bus, e[75:0]);
    check({t, ".fwd"}, 76'({ex_rf_we, ex_rf_waddr, ex_ex_result}),
          76'({e[37] & ~e[76], e[36:32], e[31:0]}));
    check({t, ".stallreq"}, 76'(stallreq_for_ex), 76'(e[76]));
    check({t, ".sram"}, 76'({data_sram_en, data_sram_wen}), 76'(e[43:39]));
  endtask

  // Drive one bundle, record its expected result, compare once it is in EX.
  task automatic send(input ins_t i, input logic [31:0] res, input logic stall_exp,
                      input string tag);
    @(negedge clk);
    id_bus = i;
    sb.push_back({stall_exp, exp_bus(i, res)});
    sb_tag.push_back(tag);
    @(posedge clk);
    #1;
    collect();
  endtask

  // Count cycles with stallreq high (the current cycle included), bounded.
  task automatic wait_div(input string tag);
    int cnt;
    cnt = 1;
    while (stallreq_for_ex && cnt < 200) begin
      @(posedge clk);
      #1;
      if (stallreq_for_ex) cnt++;
    end
    check({tag, ".stall_cycles"}, 76'(cnt), 76'(33));
  endtask

  task automatic mfhi(input logic [31:0] exp, input string tag);
    send(mk(32'hBFC0_0100, r_inst(0, 0, 5'd8, 0, 6'h10), OP_NONE, 3'b000, 4'b0000,
            1'b1, 5'd8, 32'h0, 32'h0), exp, 1'b0, tag);
  endtask

  task automatic mflo(input logic [31:0] exp, input string tag);
    send(mk(32'hBFC0_0104, r_inst(0, 0, 5'd9, 0, 6'h12), OP_NONE, 3'b000, 4'b0000,
            1'b1, 5'd9, 32'h0, 32'h0), exp, 1'b0, tag);
  endtask

  task automatic mthi_mtlo(input logic [31:0] hi, input logic [31:0] lo);
    send(mk(32'hBFC0_0200, r_inst(5'd1, 0, 0, 0, 6'h11), OP_NONE, 3'b000, 4'b0000,
            1'b0, 5'd0, hi, 32'h0), 32'h0, 1'b0, "mthi");
    send(mk(32'hBFC0_0204, r_inst(5'd1, 0, 0, 0, 6'h13), OP_NONE, 3'b000, 4'b0000,
            1'b0, 5'd0, lo, 32'h0), 32'h0, 1'b0, "mtlo");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins_t x, y, d;
    logic div_en;
`ifdef EX_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif

    // Reset: two cycles high, everything reads as a bubble.
    repeat (2) @(posedge clk);
    #1;
    check("rst.bus", ex_to_mem_bus, '0);
    check("rst.sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), '0);
    check("rst.fwd", 76'({ex_rf_we, ex_rf_waddr, ex_ex_result}), '0);
    check("rst.stallreq", 76'(stallreq_for_ex), '0);
    @(negedge clk);
    rst = 1'b0;
    mfhi(32'h0, "rst.hi");
    mflo(32'h0, "rst.lo");

    // ALU patterns.
    send(mk(32'hBFC0_0010, r_inst(5'd1, 5'd2, 5'd3, 0, 6'h21), OP_ADD, 3'b001, 4'b0001,
            1'b1, 5'd3, 32'd5, 32'd7), 32'd12, 1'b0, "addu");
    send(mk(32'hBFC0_0014, i_inst(6'h0D, 5'd1, 5'd4, 16'h000F), OP_OR, 3'b001, 4'b1000,
            1'b1, 5'd4, 32'h0000_00F0, 32'h0), 32'h0000_00FF, 1'b0, "ori");
    send(mk(32'hBFC0_0018, i_inst(6'h0F, 5'd0, 5'd6, 16'h1234), OP_LUI, 3'b000, 4'b1000,
            1'b1, 5'd6, 32'h0, 32'h0), 32'h1234_0000, 1'b0, "lui");
    send(mk(32'hBFC0_0000, {6'h03, 26'h0000_100}, OP_ADD, 3'b010, 4'b0100,
            1'b1, 5'd31, 32'h0, 32'h0), 32'hBFC0_0008, 1'b0, "jal");
    send(mk(32'hBFC0_001C, r_inst(5'd1, 5'd2, 5'd7, 0, 6'h23), OP_SUB, 3'b001, 4'b0001,
            1'b1, 5'd7, 32'd3, 32'd5), 32'hFFFF_FFFE, 1'b0, "subu");
    send(mk(32'hBFC0_0020, r_inst(0, 5'd2, 5'd5, 5'd4, 6'h00), OP_SLL, 3'b100, 4'b0001,
            1'b1, 5'd5, 32'h0, 32'h1), 32'h0000_0010, 1'b0, "sll");
    send(mk(32'hBFC0_0024, r_inst(0, 5'd2, 5'd5, 5'd4, 6'h02), OP_SRL, 3'b100, 4'b0001,
            1'b1, 5'd5, 32'h0, 32'h8000_0000), 32'h0800_0000, 1'b0, "srl");
    send(mk(32'hBFC0_0028, r_inst(0, 5'd2, 5'd5, 5'd4, 6'h03), OP_SRA, 3'b100, 4'b0001,
            1'b1, 5'd5, 32'h0, 32'h8000_0000), 32'hF800_0000, 1'b0, "sra");
    send(mk(32'hBFC0_002C, r_inst(5'd1, 5'd2, 5'd10, 0, 6'h2A), OP_SLT, 3'b001, 4'b0001,
            1'b1, 5'd10, 32'hFFFF_FFFF, 32'd1), 32'd1, 1'b0, "slt");
    send(mk(32'hBFC0_0030, r_inst(5'd1, 5'd2, 5'd10, 0, 6'h2B), OP_SLTU, 3'b001, 4'b0001,
            1'b1, 5'd10, 32'hFFFF_FFFF, 32'd1), 32'd0, 1'b0, "sltu");
    send(mk(32'hBFC0_0034, r_inst(5'd1, 5'd2, 5'd11, 0, 6'h27), OP_NOR, 3'b001, 4'b0001,
            1'b1, 5'd11, 32'hF0F0_F0F0, 32'h0F0F_0000), 32'h0000_0F0F, 1'b0, "nor");
    send(mk(32'hBFC0_0038, r_inst(5'd1, 5'd2, 5'd11, 0, 6'h26), OP_XOR, 3'b001, 4'b0001,
            1'b1, 5'd11, 32'hA5A5_A5A5, 32'hFFFF_0000), 32'h5A5A_A5A5, 1'b0, "xor");
    send(mk(32'hBFC0_003C, r_inst(5'd1, 5'd2, 5'd11, 0, 6'h24), OP_AND, 3'b001, 4'b0001,
            1'b1, 5'd11, 32'hFF00_FF00, 32'h0F0F_0F0F), 32'h0F00_0F00, 1'b0, "and");

    // Store: sign-extended offset forms the address, rt is the data.
    x = mk(32'hBFC0_0040, i_inst(6'h2B, 5'd1, 5'd2, 16'hFFFC), OP_ADD, 3'b001, 4'b0010,
           1'b0, 5'd0, 32'h0000_1000, 32'hDEAD_BEEF);
    x.ram_en  = 1'b1;
    x.ram_wen = 4'hF;
    send(x, 32'h0000_0FFC, 1'b0, "sw");
    check("sw.addr", 76'(data_sram_addr), 76'(32'h0000_0FFC));
    check("sw.wdata", 76'(data_sram_wdata), 76'(32'hDEAD_BEEF));

    // HI/LO: multiplies and moves.
    send(mk(32'hBFC0_0050, r_inst(5'd1, 5'd2, 0, 0, 6'h18), OP_NONE, 3'b000, 4'b0000,
            1'b0, 5'd0, 32'hFFFF_FFFD, 32'd5), 32'h0, 1'b0, "mult");
    mfhi(32'hFFFF_FFFF, "mult.hi");
    mflo(32'hFFFF_FFF1, "mult.lo");
    send(mk(32'hBFC0_0054, r_inst(5'd1, 5'd2, 0, 0, 6'h19), OP_NONE, 3'b000, 4'b0000,
            1'b0, 5'd0, 32'hFFFF_FFFF, 32'd2), 32'h0, 1'b0, "multu");
    mfhi(32'h0000_0001, "multu.hi");
    mflo(32'hFFFF_FFFE, "multu.lo");
    mthi_mtlo(32'h2222_2222, 32'h1111_1111);
    mfhi(32'h2222_2222, "mthi.hi");
    mflo(32'h1111_1111, "mtlo.lo");

    // Stall: EX and MEM both stopped hold the bundle; EX stopped alone inserts a bubble.
    x = mk(32'hBFC0_0060, r_inst(5'd1, 5'd2, 5'd3, 0, 6'h21), OP_ADD, 3'b001, 4'b0001,
           1'b1, 5'd3, 32'd20, 32'd22);
    y = mk(32'hBFC0_0064, r_inst(5'd1, 5'd2, 5'd12, 0, 6'h21), OP_ADD, 3'b001, 4'b0001,
           1'b1, 5'd12, 32'd1, 32'd1);
    send(x, 32'd42, 1'b0, "hold.first");
    @(negedge clk);
    stall_tb = 6'b001100;
    id_bus   = y;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("hold.bus", ex_to_mem_bus, exp_bus(x, 32'd42));
    end
    @(negedge clk);
    stall_tb = 6'b000100;
    @(posedge clk);
    #1;
    check("bubble.bus", ex_to_mem_bus, '0);
    check("bubble.fwd", 76'({ex_rf_we, ex_rf_waddr, ex_ex_result}), '0);
    stall_tb = 6'b000000;

    // Signed divide -7 / 2; the bundle carries rf_we to observe forwarding suppression.
    d = mk(32'hBFC0_0070, r_inst(5'd1, 5'd2, 0, 0, 6'h1A), OP_NONE, 3'b000, 4'b0000,
           1'b1, 5'd5, 32'hFFFF_FFF9, 32'd2);
    send(d, 32'h0, div_en, "div");
    if (div_en) begin
      wait_div("div");
      check("div.done_fwd_we", 76'(ex_rf_we), 76'(1'b1));
      mflo(32'hFFFF_FFFD, "div.lo");
      mfhi(32'hFFFF_FFFF, "div.hi");
    end else begin
      mflo(32'h1111_1111, "divnop.lo");
      mfhi(32'h2222_2222, "divnop.hi");
    end

    // Unsigned divide by zero, then held in EX after completion: must not restart.
    d = mk(32'hBFC0_0080, r_inst(5'd1, 5'd2, 0, 0, 6'h1B), OP_NONE, 3'b000, 4'b0000,
           1'b0, 5'd0, 32'd100, 32'd0);
    send(d, 32'h0, div_en, "divu0");
    if (div_en) begin
      wait_div("divu0");
      stall_tb = 6'b001111;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        check("divu0.no_restart", 76'(stallreq_for_ex), '0);
      end
      stall_tb = 6'b000000;
      mflo(32'hFFFF_FFFF, "divu0.lo");
      mfhi(32'd100, "divu0.hi");
    end else begin
      mflo(32'h1111_1111, "divu0nop.lo");
      mfhi(32'h2222_2222, "divu0nop.hi");
    end

    // Reset during RUN: divider abandoned, HI/LO cleared.
    mthi_mtlo(32'h3333_3333, 32'h4444_4444);
    d = mk(32'hBFC0_0090, r_inst(5'd1, 5'd2, 0, 0, 6'h1B), OP_NONE, 3'b000, 4'b0000,
           1'b0, 5'd0, 32'd100, 32'd7);
    send(d, 32'h0, div_en, "divrst");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("divrst.stallreq", 76'(stallreq_for_ex), '0);
    check("divrst.bus", ex_to_mem_bus, '0);
    @(negedge clk);
    rst    = 1'b0;
    id_bus = '0;
    mfhi(32'h0, "divrst.hi");
    mflo(32'h0, "divrst.lo");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
